// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Constants, state encoding and helpers shared by the FFT blocks.
// Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  // Default transform size.
  localparam int unsigned c_fft_addr_width = 9;
  localparam int unsigned c_fft_n          = 1 << c_fft_addr_width;

  // Loader sequencer state encoding.
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_load  = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  // Bit reversal at the default address width, for the twiddle/output stages.
  function automatic logic [c_fft_addr_width-1:0] bitrev(
    input logic [c_fft_addr_width-1:0] a
  );
    logic [c_fft_addr_width-1:0] r;
    for (int i = 0; i < int'(c_fft_addr_width); i++) begin
      r[i] = a[int'(c_fft_addr_width)-1-i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/addr_bitrev.sv
`default_nettype none
// ============================================================================
// Module   : addr_bitrev
// Brief    : Combinational address bit reversal, bypassed when BITREV = 0.
// Revision : 1.0 - initial release
// ============================================================================
module addr_bitrev #(
  parameter int ADDR_WIDTH = 9,
  parameter bit BITREV     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] addr_out
);

  generate
    if (BITREV) begin : g_rev
      // Pure wiring: output bit i takes input bit (ADDR_WIDTH-1-i).
      for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_bit
        assign addr_out[i] = addr_in[ADDR_WIDTH-1-i];
      end
    end else begin : g_pass
      assign addr_out = addr_in;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fft_in_loader.sv
`default_nettype none
// ============================================================================
// Module   : fft_in_loader
// Brief    : Streams the input-sample ROM into the FFT working RAM, writing
//            each sample at its bit-reversed address for in-place DIT.
// Revision : 1.0 - initial release
// ============================================================================
module fft_in_loader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 9,
  parameter int OUT_WIDTH  = 16,
  parameter bit BITREV     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [OUT_WIDTH-1:0]  ram_data
);

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

  logic [1:0]            r_state;
  logic                  r_drain;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_vld1;
  logic [ADDR_WIDTH-1:0] r_addr1;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic signed [OUT_WIDTH-1:0] w_sext;

  assign rom_addr = r_cnt;
  assign busy     = (r_state == c_st_load) || (r_state == c_st_drain);
  assign done     = (r_state == c_st_done);

  // Signed size cast replicates the sample's sign bit up to OUT_WIDTH.
  assign w_sext = OUT_WIDTH'($signed(rom_q));

  addr_bitrev #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .BITREV     (BITREV)
  ) u_addr_bitrev (
    .addr_in  (r_addr1),
    .addr_out (w_wr_addr)
  );

  // Sequencer: one pass over the ROM, two flush cycles, then a done pulse.
  // DONE also accepts start so back-to-back loads lose no cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_drain <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state <= c_st_load;
            r_cnt   <= '0;
          end
        end
        c_st_load: begin
          if (r_cnt == c_last_addr) begin
            // Counter parks at N-1; no second pass.
            r_state <= c_st_drain;
            r_drain <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_drain: begin
          if (r_drain) begin
            r_state <= c_st_done;
          end else begin
            r_drain <= 1'b1;
          end
        end
        c_st_done: begin
          if (start) begin
            r_state <= c_st_load;
            r_cnt   <= '0;
          end else begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Two-stage write pipeline: stage 1 aligns the issued address with the
  // registered ROM output, stage 2 registers the RAM write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld1   <= 1'b0;
      r_addr1  <= '0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      r_vld1   <= (r_state == c_st_load);
      r_addr1  <= r_cnt;
      ram_we   <= r_vld1;
      ram_addr <= w_wr_addr;
      ram_data <= w_sext;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_in_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_in_loader
// Brief    : Directed self-checking bench for fft_in_loader (defaults, plus a
//            natural-order instance sharing the same control inputs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_in_loader;

  localparam int N = 512;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy, done, ram_we;
  logic [8:0]  rom_addr, ram_addr;
  logic [8:0]  rom_q;
  logic [15:0] ram_data;
  logic        busy2, done2, ram_we2;
  logic [8:0]  rom_addr2, ram_addr2;
  logic [8:0]  rom_q2;
  logic [15:0] ram_data2;

  int rom_mode;   // 0: mem[i]=i, 1: mem[i]=-1, 2: mem[i]=255
  int checks   = 0;
  int failures = 0;
  logic [15:0] ram [0:N-1];

  fft_in_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rom_addr (rom_addr),
    .rom_q    (rom_q),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
  );

  fft_in_loader #(.BITREV(1'b0)) dut_nat (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy2),
    .done     (done2),
    .rom_addr (rom_addr2),
    .rom_q    (rom_q2),
    .ram_we   (ram_we2),
    .ram_addr (ram_addr2),
    .ram_data (ram_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] rom_val(input int mode, input logic [8:0] a);
    case (mode)
      1:       return 9'h1FF;
      2:       return 9'd255;
      default: return a;
    endcase
  endfunction

  // Registered ROM models: q follows addr by one clock.
  always @(posedge clk) begin
    rom_q  <= rom_val(rom_mode, rom_addr);
    rom_q2 <= rom_val(rom_mode, rom_addr2);
  end

  function automatic logic [8:0] rev9(input logic [8:0] a);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = a[8-i];
    return r;
  endfunction

  function automatic logic [15:0] exp_data(input int mode, input int i);
    logic [8:0] s;
    s = rom_val(mode, 9'(i));
    return {{7{s[8]}}, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start asserted in cycle 0 (current cycle); steps through cycle N+3 and
  // checks every cycle's control/address timing plus each written word.
  task automatic run_load(input int mode, input bit hold);
    int wr = 0;
    int dn = 0;
    rom_mode = mode;
    for (int i = 0; i < N; i++) ram[i] = 'x;
    start = 1'b1;
    for (int k = 1; k <= N + 3; k++) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      chk("busy", 32'(busy), 32'(k <= N + 2));
      chk("done", 32'(done), 32'(k == N + 3));
      chk("ram_we", 32'(ram_we), 32'(k >= 3 && k <= N + 2));
      chk("rom_addr", 32'(rom_addr), (k <= N) ? 32'(k - 1) : 32'(N - 1));
      chk("nat_ram_we", 32'(ram_we2), 32'(k >= 3 && k <= N + 2));
      if (done) dn++;
      if (ram_we) begin
        chk("wr_addr", 32'(ram_addr), 32'(rev9(9'(k - 3))));
        chk("wr_data", 32'(ram_data), 32'(exp_data(mode, k - 3)));
        ram[ram_addr] = ram_data;
        wr++;
      end
      if (ram_we2 && mode == 0) begin
        chk("nat_addr_eq_data", 32'(ram_addr2), 32'(ram_data2[8:0]));
      end
    end
    chk("write_count", 32'(wr), 32'(N));
    chk("done_count", 32'(dn), 32'd1);
    for (int i = 0; i < N; i++) begin
      chk("ram_content", 32'(ram[rev9(9'(i))]), 32'(exp_data(mode, i)));
    end
  endtask

  initial begin
    int wr;
    int dn;
    rst      = 1'b1;
    start    = 1'b0;
    rom_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_data", 32'(ram_data), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp ROM: sample 1 lands at 256; sample 256 (9'h100 = -256) lands at 1.
    run_load(0, 1'b0);
    chk("ram256", 32'(ram[256]), 32'h0001);
    chk("ram1", 32'(ram[1]), 32'hFF00);
    repeat (2) @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);

    run_load(1, 1'b0);          // every word 16'hFFFF
    repeat (2) @(posedge clk); #1;
    run_load(2, 1'b0);          // every word 16'h00FF
    repeat (2) @(posedge clk); #1;

    // Start held high: accepted again in the DONE cycle (N+3).
    run_load(0, 1'b1);
    @(posedge clk); #1;          // cycle N+4
    chk("hold_restart_busy", 32'(busy), 32'd1);
    chk("hold_restart_addr", 32'(rom_addr), 32'd0);
    chk("hold_restart_done", 32'(done), 32'd0);
    start = 1'b0;
    wr = 0;
    dn = 0;
    for (int k = 0; k < N + 20; k++) begin
      if (ram_we) wr++;
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("hold_second_writes", 32'(wr), 32'(N));
    chk("hold_second_done", 32'(dn), 32'd1);

    // Reset at cycle 100 of a load.
    rom_mode = 0;
    start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_rst_ram_we", 32'(ram_we), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;          // cycle 101
    rst = 1'b0;
    chk("midrst_ram_we", 32'(ram_we), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    wr = 0;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      if (ram_we) wr++;
      if (done || busy) dn++;
      @(posedge clk); #1;
    end
    chk("midrst_no_writes", 32'(wr), 32'd0);
    chk("midrst_no_done", 32'(dn), 32'd0);
    run_load(0, 1'b0);          // restart must give a full load
    repeat (2) @(posedge clk); #1;

    // Reset and start together in IDLE: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    wr = 0;
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      if (ram_we || busy) wr++;
      if (done) dn++;
      @(posedge clk); #1;
    end
    chk("rst_start_idle", 32'(wr), 32'd0);
    chk("rst_start_no_done", 32'(dn), 32'd0);
    chk("rst_start_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
